// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous input: a multi-flop synchronizer followed by a
// counter-based stability filter that also flags and counts aborted transitions.
module input_debouncer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DEBOUNCE_COUNT = 1000000,
  parameter int unsigned CNT_WIDTH      = 20,
  parameter logic        RESET_LEVEL    = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       signal_i,
  input  logic       glitch_clr_i,
  output logic       debounced_o,
  output logic       busy_o,
  output logic       glitch_o,
  output logic [7:0] glitch_cnt_o
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    ARM_HI    = 2'd1,
    STABLE_HI = 2'd2,
    ARM_LO    = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_COUNT - 1);

  generate
    if (SYNC_STAGES < 2) begin : g_chk_sync
      $error("input_debouncer: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_COUNT < 1) begin : g_chk_count
      $error("input_debouncer: DEBOUNCE_COUNT must be at least 1");
    end
    if ((64'd1 << CNT_WIDTH) < 64'(DEBOUNCE_COUNT)) begin : g_chk_width
      $error("input_debouncer: CNT_WIDTH too small for DEBOUNCE_COUNT");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   sync_q;

  state_t                 state_reg;
  logic [CNT_WIDTH-1:0]   count_reg;
  logic                   debounced_reg;
  logic                   busy_reg;
  logic                   glitch_reg;
  logic [7:0]             glitch_cnt_reg;

  // Synchronizer chain: stage 0 samples the raw pin, each later stage the one before.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = signal_i;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_reg <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_reg <= sync_next;
    end
  end

  assign sync_q = sync_reg[SYNC_STAGES-1];

  // Stability filter; every output is registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= RESET_LEVEL ? STABLE_HI : STABLE_LO;
      count_reg     <= '0;
      debounced_reg <= RESET_LEVEL;
      busy_reg      <= 1'b0;
      glitch_reg    <= 1'b0;
    end else begin
      glitch_reg <= 1'b0;
      case (state_reg)
        STABLE_LO: begin
          if (sync_q) begin
            state_reg <= ARM_HI;
            busy_reg  <= 1'b1;
            count_reg <= '0;
          end
        end
        ARM_HI: begin
          if (!sync_q) begin
            state_reg  <= STABLE_LO;
            busy_reg   <= 1'b0;
            glitch_reg <= 1'b1;
            count_reg  <= '0;
          end else if (count_reg == CNT_LAST) begin
            state_reg     <= STABLE_HI;
            busy_reg      <= 1'b0;
            debounced_reg <= 1'b1;
            count_reg     <= '0;
          end else begin
            count_reg <= count_reg + CNT_WIDTH'(1);
          end
        end
        STABLE_HI: begin
          if (!sync_q) begin
            state_reg <= ARM_LO;
            busy_reg  <= 1'b1;
            count_reg <= '0;
          end
        end
        ARM_LO: begin
          if (sync_q) begin
            state_reg  <= STABLE_HI;
            busy_reg   <= 1'b0;
            glitch_reg <= 1'b1;
            count_reg  <= '0;
          end else if (count_reg == CNT_LAST) begin
            state_reg     <= STABLE_LO;
            busy_reg      <= 1'b0;
            debounced_reg <= 1'b0;
            count_reg     <= '0;
          end else begin
            count_reg <= count_reg + CNT_WIDTH'(1);
          end
        end
        default: begin
          state_reg     <= STABLE_LO;
          busy_reg      <= 1'b0;
          debounced_reg <= 1'b0;
          count_reg     <= '0;
        end
      endcase
    end
  end

  // Abort counter advances while the glitch pulse is visible; a clear in that cycle wins.
  always_ff @(posedge clk_i) begin
    if (rst_i || glitch_clr_i) begin
      glitch_cnt_reg <= 8'd0;
    end else if (glitch_reg && (glitch_cnt_reg != 8'hFF)) begin
      glitch_cnt_reg <= glitch_cnt_reg + 8'd1;
    end
  end

  assign debounced_o  = debounced_reg;
  assign busy_o       = busy_reg;
  assign glitch_o     = glitch_reg;
  assign glitch_cnt_o = glitch_cnt_reg;

endmodule

// File: tb/tb_input_debouncer.sv
// Randomized + directed bench for input_debouncer, checked every cycle against a
// run-length model of the filter plus literal latency / count expectations.
module tb_input_debouncer;
  localparam int SYNC = 2;
  localparam int DC   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sig = 1'b0;
  logic       clr = 1'b0;
  logic       sig1 = 1'b1;
  logic       deb, busy, glitch;
  logic [7:0] gcnt;
  logic       deb1, busy1, glitch1;
  logic [7:0] gcnt1;

  int checks = 0;
  int errors = 0;
  int glitch_pulses = 0;

  // Model state: raw samples in flight through the synchronizer, accepted level,
  // length of the current run of "differs from accepted level", pulse and count.
  bit hist[$];
  bit m_deb;
  bit m_glitch;
  int m_run;
  int m_cnt;
  bit m_valid = 1'b0;

  bit train [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

  always #5 clk = ~clk;

  input_debouncer #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_COUNT(DC), .CNT_WIDTH(3), .RESET_LEVEL(1'b0)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .signal_i(sig), .glitch_clr_i(clr),
    .debounced_o(deb), .busy_o(busy), .glitch_o(glitch), .glitch_cnt_o(gcnt)
  );

  input_debouncer #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_COUNT(DC), .CNT_WIDTH(3), .RESET_LEVEL(1'b1)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst), .signal_i(sig1), .glitch_clr_i(1'b0),
    .debounced_o(deb1), .busy_o(busy1), .glitch_o(glitch1), .glitch_cnt_o(gcnt1)
  );

  function automatic void check_bit(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void check_byte(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // A new level is accepted once the synchronized value has differed from the
  // accepted level on DC+1 consecutive edges; a shorter run that ends is an abort.
  function automatic void model_step();
    bit seen;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
      m_deb    = 1'b0;
      m_run    = 0;
      m_glitch = 1'b0;
      m_cnt    = 0;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      seen = hist.pop_front();
      hist.push_back(sig);
      if (clr) m_cnt = 0;
      else if (m_glitch && m_cnt < 255) m_cnt = m_cnt + 1;
      m_glitch = 1'b0;
      if (seen != m_deb) begin
        m_run = m_run + 1;
        if (m_run == DC + 1) begin
          m_deb = seen;
          m_run = 0;
        end
      end else begin
        if (m_run > 0) m_glitch = 1'b1;
        m_run = 0;
      end
    end
  endfunction

  function automatic void compare_cycle();
    if (m_valid) begin
      if (glitch === 1'b1) glitch_pulses++;
      check_bit("debounced", deb, m_deb);
      check_bit("busy", busy, m_run > 0);
      check_bit("glitch", glitch, m_glitch);
      check_byte("glitch_cnt", gcnt, 8'(m_cnt));
      check_bit("rl1_debounced", deb1, 1'b1);
      check_bit("rl1_busy", busy1, 1'b0);
      check_bit("rl1_glitch", glitch1, 1'b0);
      check_byte("rl1_glitch_cnt", gcnt1, 8'd0);
    end
  endfunction

  always @(posedge clk) model_step();
  always @(negedge clk) compare_cycle();

  task automatic hold(input bit v);
    @(negedge clk);
    sig = v;
  endtask

  task automatic bounce(input int n_high, input int n_low);
    hold(1'b1);
    repeat (n_high) @(negedge clk);
    sig = 1'b0;
    repeat (n_low) @(negedge clk);
  endtask

  // Counts edges until debounced_o reaches v; edges stays 0 if the bound expires.
  task automatic wait_level(input bit v, output int edges, output int busy_n, output int gl_n);
    edges  = 0;
    busy_n = 0;
    gl_n   = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      busy_n += int'(busy === 1'b1);
      gl_n   += int'(glitch === 1'b1);
      if (deb === v) begin
        edges = k;
        return;
      end
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  e, b, g, p0, rise_edge;
    bit  found;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    repeat (20) @(negedge clk);
    check_bit("s1_deb_low", deb, 1'b0);
    check_byte("s1_cnt_zero", gcnt, 8'd0);
    $display("s1 idle: debounced=%0d glitch_cnt=%0d", deb, gcnt);

    hold(1'b1);
    wait_level(1'b1, e, b, g);
    check_int("s2_rise_edges", e, 7);
    check_int("s2_busy_cycles", b, 4);
    check_int("s2_glitches", g, 0);
    $display("s2 rise: edges=%0d busy_cycles=%0d", e, b);
    repeat (5) @(negedge clk);
    hold(1'b0);
    wait_level(1'b0, e, b, g);
    check_int("s2_fall_edges", e, 7);
    check_int("s2_fall_glitches", g, 0);
    $display("s2 fall: edges=%0d", e);
    repeat (5) @(negedge clk);

    p0 = glitch_pulses;
    bounce(3, 8);
    check_bit("s3_deb_stays_low", deb, 1'b0);
    check_int("s3_glitch_pulses", glitch_pulses - p0, 1);
    check_byte("s3_cnt_one", gcnt, 8'd1);
    $display("s3 bounce: glitch_cnt=%0d", gcnt);
    for (int i = 0; i < 300; i++) bounce(3, 3);
    repeat (6) @(negedge clk);
    check_byte("s3_cnt_saturated", gcnt, 8'hFF);
    check_bit("s3_deb_after_bounces", deb, 1'b0);
    $display("s3 saturation: glitch_cnt=%0d", gcnt);
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    check_byte("s3_cnt_cleared", gcnt, 8'd0);

    // Last 0->1 of the train is sampled on edge 6, so the rise lands on edge 12.
    rise_edge = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k > 0 && rise_edge == 0 && deb === 1'b1) rise_edge = k;
      sig = (k < 9) ? train[k] : 1'b1;
    end
    check_int("s4_rise_edge", rise_edge, 12);
    check_byte("s4_cnt_two", gcnt, 8'd2);
    $display("s4 train: rise_edge=%0d glitch_cnt=%0d", rise_edge, gcnt);
    hold(1'b0);
    wait_level(1'b0, e, b, g);
    check_int("s4_fall_edges", e, 7);
    repeat (3) @(negedge clk);

    p0 = glitch_pulses;
    hold(1'b1);
    repeat (5) @(negedge clk);
    check_bit("s5_busy_before_reset", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_bit("s5_deb_reset", deb, 1'b0);
    check_bit("s5_busy_reset", busy, 1'b0);
    check_bit("s5_glitch_reset", glitch, 1'b0);
    check_byte("s5_cnt_reset", gcnt, 8'd0);
    rst = 1'b0;
    wait_level(1'b1, e, b, g);
    check_int("s5_rise_edges", e, 7);
    check_int("s5_glitch_pulses", glitch_pulses - p0, 0);
    $display("s5 reset mid-arm: rise edges after release=%0d", e);
    hold(1'b0);
    wait_level(1'b0, e, b, g);
    repeat (3) @(negedge clk);

    bounce(3, 6);
    check_byte("s6_cnt_before_clear", gcnt, 8'd1);
    hold(1'b1);
    repeat (3) @(negedge clk);
    sig = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (glitch === 1'b1) begin
        clr = 1'b1;
        found = 1'b1;
        break;
      end
    end
    @(negedge clk);
    clr = 1'b0;
    check_bit("s6_glitch_seen", found, 1'b1);
    check_byte("s6_clear_wins", gcnt, 8'd0);
    check_bit("s6_rl1_deb_high", deb1, 1'b1);
    $display("s6 clear vs glitch: glitch_cnt=%0d rl1_debounced=%0d", gcnt, deb1);

    for (int t = 0; t < 40; t++) begin
      int len;
      len = $urandom_range(1, 7);
      hold(1'($urandom_range(0, 1)));
      repeat (len - 1) @(negedge clk);
      if ((t % 13) == 12) clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
    end
    hold(1'b0);
    repeat (12) @(negedge clk);
    $display("s7 random: debounced=%0d glitch_cnt=%0d", deb, gcnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
